// File: rtl/bcd_seq_monitor.sv
// Lock-and-track monitor for an upstream F,D,B,9 odd-descending counter.
// Counts completed laps in packed BCD and escalates repeated mismatches to a sticky FAULT.
module bcd_seq_monitor #(
    parameter int ERR_LIMIT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [3:0] D,
    output logic       LOCK,
    output logic       FAULT,
    output logic       ERR,
    output logic [3:0] ERR_CNT,
    output logic [7:0] LAP_BCD,
    output logic       LAP_PULSE
);

    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t     state, state_n;
    logic [3:0] exp_code, exp_code_n;
    logic [3:0] err_cnt_n, err_cnt_inc;
    logic [7:0] lap_bcd_n;
    logic       err_n, lap_pulse_n;

    function automatic logic [3:0] next_code(input logic [3:0] cur);
        case (cur)
            4'hF:    next_code = 4'hD;
            4'hD:    next_code = 4'hB;
            4'hB:    next_code = 4'h9;
            default: next_code = 4'hF;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] cur);
        logic [3:0] tens, units;
        tens  = cur[7:4];
        units = cur[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        bcd_inc = {tens, units};
    endfunction

    assign err_cnt_inc = (ERR_CNT == 4'hF) ? 4'hF : ERR_CNT + 4'd1;

    always_comb begin
        state_n     = state;
        exp_code_n  = exp_code;
        err_cnt_n   = ERR_CNT;
        lap_bcd_n   = LAP_BCD;
        err_n       = 1'b0;
        lap_pulse_n = 1'b0;
        if (EN) begin
            case (state)
                ST_SEARCH: begin
                    if (D == 4'hF) begin
                        state_n    = ST_LOCKED;
                        exp_code_n = 4'hD;
                    end
                end
                ST_LOCKED: begin
                    if (D == exp_code) begin
                        exp_code_n = next_code(exp_code);
                        if (exp_code == 4'h9) begin
                            lap_pulse_n = 1'b1;
                            lap_bcd_n   = bcd_inc(LAP_BCD);
                        end
                    end else begin
                        // A mismatching F only drops lock; relocking needs a fresh sample.
                        err_n      = 1'b1;
                        err_cnt_n  = err_cnt_inc;
                        exp_code_n = 4'hF;
                        state_n    = (err_cnt_inc >= LIMIT) ? ST_FAULT : ST_SEARCH;
                    end
                end
                default: begin
                    state_n = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_SEARCH;
            exp_code  <= 4'hF;
            ERR_CNT   <= 4'h0;
            LAP_BCD   <= 8'h00;
            ERR       <= 1'b0;
            LAP_PULSE <= 1'b0;
        end else begin
            state     <= state_n;
            exp_code  <= exp_code_n;
            ERR_CNT   <= err_cnt_n;
            LAP_BCD   <= lap_bcd_n;
            ERR       <= err_n;
            LAP_PULSE <= lap_pulse_n;
        end
    end

    assign LOCK  = (state == ST_LOCKED);
    assign FAULT = (state == ST_FAULT);

endmodule

// File: tb/tb_bcd_seq_monitor.sv
// Directed bench for bcd_seq_monitor: laps, mismatches, hold, fault, BCD carry/wrap and reset priority.
module tb_bcd_seq_monitor;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       EN = 1'b0;
    logic [3:0] D = 4'h0;
    logic       LOCK, FAULT, ERR, LAP_PULSE;
    logic [3:0] ERR_CNT;
    logic [7:0] LAP_BCD;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] laps;
    logic [3:0] lapCode [4];

    bcd_seq_monitor #(.ERR_LIMIT(3)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .D(D),
        .LOCK(LOCK), .FAULT(FAULT), .ERR(ERR), .ERR_CNT(ERR_CNT),
        .LAP_BCD(LAP_BCD), .LAP_PULSE(LAP_PULSE)
    );

    always #5 CLK = ~CLK;

    // Reference lap counter: go through binary so the BCD carry is derived independently.
    function automatic logic [7:0] bcdNext(input logic [7:0] b);
        int n;
        logic [3:0] t, u;
        n = (int'(b[7:4]) * 10 + int'(b[3:0]) + 1) % 100;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    function automatic logic [15:0] expVec(input logic l, input logic f, input logic e,
                                           input logic [3:0] c, input logic [7:0] b,
                                           input logic p);
        return {l, f, e, c, b, p};
    endfunction

    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] d);
        RESET = rst;
        EN    = en;
        D     = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        logic [15:0] observed;
        observed = {LOCK, FAULT, ERR, ERR_CNT, LAP_BCD, LAP_PULSE};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h (lock,fault,err,cnt,lap,pulse)",
                   tag, observed, expected);
        end
    endtask

    // One clean lap while locked with the given error count.
    task automatic cleanLap(input string tag, input logic [3:0] cnt);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, lapCode[i]);
            if (i == 3) begin
                laps = bcdNext(laps);
                checkOutput(tag, expVec(1, 0, 0, cnt, laps, 1));
            end else begin
                checkOutput(tag, expVec(1, 0, 0, cnt, laps, 0));
            end
        end
    endtask

    initial begin
        lapCode[0] = 4'hF; lapCode[1] = 4'hD; lapCode[2] = 4'hB; lapCode[3] = 4'h9;
        laps = 8'h00;

        applyStimulus(1'b0, 1'b1, 4'hF);
        checkOutput("reset", expVec(0, 0, 0, 0, 8'h00, 0));
        applyStimulus(1'b1, 1'b1, 4'h3);
        checkOutput("search_ignore", expVec(0, 0, 0, 0, 8'h00, 0));

        for (int l = 0; l < 3; l++) cleanLap("lap3", 4'd0);
        checkOutput("lap3_total", expVec(1, 0, 0, 0, 8'h03, 1));

        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("mm1_f", expVec(1, 0, 0, 0, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'hD);
        checkOutput("mm1_d", expVec(1, 0, 0, 0, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'h7);
        checkOutput("mm1_err", expVec(0, 0, 1, 1, laps, 0));
        cleanLap("relock1", 4'd1);

        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("mm2_f", expVec(1, 0, 0, 1, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("mm2_err_f", expVec(0, 0, 1, 2, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("relock2", expVec(1, 0, 0, 2, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'hD);
        checkOutput("hold_pre", expVec(1, 0, 0, 2, laps, 0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0);
            checkOutput("en_hold", expVec(1, 0, 0, 2, laps, 0));
        end
        applyStimulus(1'b1, 1'b1, 4'hB);
        checkOutput("hold_b", expVec(1, 0, 0, 2, laps, 0));
        applyStimulus(1'b1, 1'b1, 4'h9);
        laps = bcdNext(laps);
        checkOutput("hold_lap", expVec(1, 0, 0, 2, 8'h05, 1));

        applyStimulus(1'b1, 1'b1, 4'h7);
        checkOutput("mm3_fault", expVec(0, 1, 1, 3, 8'h05, 0));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, lapCode[i % 4]);
            checkOutput("fault_sticky", expVec(0, 1, 0, 3, 8'h05, 0));
        end
        applyStimulus(1'b0, 1'b1, 4'hF);
        checkOutput("fault_reset", expVec(0, 0, 0, 0, 8'h00, 0));

        laps = 8'h00;
        for (int l = 0; l < 100; l++) begin
            cleanLap("lap100", 4'd0);
            if (l == 9)  checkOutput("carry_10", expVec(1, 0, 0, 0, 8'h10, 1));
            if (l == 98) checkOutput("lap_99", expVec(1, 0, 0, 0, 8'h99, 1));
        end
        checkOutput("wrap_00", expVec(1, 0, 0, 0, 8'h00, 1));

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, lapCode[i]);
        checkOutput("midlap", expVec(1, 0, 0, 0, 8'h00, 0));
        applyStimulus(1'b0, 1'b1, 4'h9);
        checkOutput("reset_midlap", expVec(0, 0, 0, 0, 8'h00, 0));
        applyStimulus(1'b1, 1'b1, 4'h9);
        checkOutput("post_reset_9", expVec(0, 0, 0, 0, 8'h00, 0));
        applyStimulus(1'b1, 1'b1, 4'hF);
        checkOutput("post_reset_lock", expVec(1, 0, 0, 0, 8'h00, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
